// File: rtl/tinyalu_cmd_issuer.sv
// Command issuer for the TinyALU: queues operand/opcode commands, runs the ALU
// start/done handshake one operation at a time and returns results on a response stream.
module tinyalu_cmd_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  output logic        alu_reset_n,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [AW:0]   PTR_INC = 1;
  localparam logic [CW-1:0] CNT_INC = 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_RST = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, NOOP, ARST} state_t;

  state_t state, state_next;

  logic [18:0]   mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, push, pop;
  logic [18:0]   head;
  logic [2:0]    head_op;
  logic [CW-1:0] cnt;

  logic          rsp_write;
  logic [15:0]   wr_result;
  logic [2:0]    wr_op;
  logic          wr_err;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full && !reset;
  assign push    = cmd_valid && cmd_ready;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign head_op = head[18:16];

  assign alu_start = (state == BUSY) || (state == NOOP);
  assign busy      = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_b, cmd_a};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_INC;
      if (pop)  rd_ptr <= rd_ptr + PTR_INC;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    rsp_write  = 1'b0;
    wr_result  = 16'h0000;
    wr_op      = alu_op;
    wr_err     = 1'b0;
    case (state)
      IDLE: begin
        // A new op only starts once its response will have somewhere to go.
        if (!empty && (!rsp_valid || rsp_ready)) begin
          pop = 1'b1;
          case (head_op)
            OP_ADD, OP_AND, OP_XOR, OP_MUL: state_next = BUSY;
            OP_NOP: state_next = NOOP;
            OP_RST: state_next = ARST;
            default: begin
              rsp_write = 1'b1;
              wr_op     = head_op;
              wr_err    = 1'b1;
            end
          endcase
        end
      end
      BUSY: begin
        if (alu_done) begin
          rsp_write  = 1'b1;
          wr_result  = alu_result;
          state_next = IDLE;
        end else if (cnt == CNT_MAX) begin
          rsp_write  = 1'b1;
          wr_err     = 1'b1;
          state_next = ARST;
        end
      end
      NOOP:    state_next = IDLE;
      ARST:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      alu_a       <= 8'h00;
      alu_b       <= 8'h00;
      alu_op      <= 3'b000;
      alu_reset_n <= 1'b0;
      cnt         <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= 16'h0000;
      rsp_op      <= 3'b000;
      rsp_err     <= 1'b0;
    end else begin
      state       <= state_next;
      alu_reset_n <= (state_next != ARST);
      cnt         <= (state == BUSY) ? cnt + CNT_INC : '0;
      if (pop) {alu_op, alu_b, alu_a} <= head;
      // A write in the same cycle as a drain replaces the old response.
      if (rsp_write) begin
        rsp_valid  <= 1'b1;
        rsp_result <= wr_result;
        rsp_op     <= wr_op;
        rsp_err    <= wr_err;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tinyalu_cmd_issuer.sv
// Directed testbench for tinyalu_cmd_issuer; the bench plays the role of the ALU
// and checks every scenario against hand-computed values.
module tb_tinyalu_cmd_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a, cmd_b;
  logic [2:0]  cmd_op;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_start, alu_reset_n, alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_err, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tinyalu_cmd_issuer #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_start(alu_start), .alu_reset_n(alu_reset_n),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_err(rsp_err),
    .busy(busy)
  );

  // Advance to just past the next rising edge; inputs set here are seen at the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_op = 3'b000;
    alu_done = 1'b0; alu_result = 16'h0000; rsp_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({alu_start, alu_reset_n, rsp_valid, busy, cmd_ready} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got start/rstn/rvalid/busy/ready=%b want 00000",
               {alu_start, alu_reset_n, rsp_valid, busy, cmd_ready});
    end
    checks++;
    if ({rsp_result, rsp_op, rsp_err} !== 20'h00000) begin
      errors++;
      $display("[TB] FAIL reset_rsp: got result=%h op=%b err=%b want 0", rsp_result, rsp_op, rsp_err);
    end
    checks++;
    if ({alu_a, alu_b, alu_op} !== 19'h00000) begin
      errors++;
      $display("[TB] FAIL reset_operands: got a=%h b=%h op=%b want 0", alu_a, alu_b, alu_op);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || alu_reset_n !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: got ready=%b rstn=%b want ready=1 rstn=0", cmd_ready, alu_reset_n);
    end
    tick();
    checks++;
    if (alu_reset_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_rstn_return: got rstn=%b busy=%b want rstn=1 busy=0", alu_reset_n, busy);
    end
  endtask

  task automatic test_add();
    offer(8'hFF, 8'h01, 3'b001);
    tick();                       // E0: accepted
    cmd_valid = 1'b0;
    checks++;
    if (alu_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_after_push: got start=%b busy=%b want start=0 busy=1", alu_start, busy);
    end
    tick();                       // E1: popped
    checks++;
    if (alu_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_start_latency: got start=%b want 1", alu_start);
    end
    checks++;
    if ({alu_a, alu_b, alu_op} !== {8'hFF, 8'h01, 3'b001}) begin
      errors++;
      $display("[TB] FAIL add_operands: got a=%h b=%h op=%b want a=ff b=01 op=001", alu_a, alu_b, alu_op);
    end
    tick(); tick();
    alu_done = 1'b1; alu_result = 16'h0100;
    tick();
    alu_done = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_op, rsp_result} !== {1'b1, 1'b0, 3'b001, 16'h0100}) begin
      errors++;
      $display("[TB] FAIL add_response: got valid=%b err=%b op=%b result=%h want 1 0 001 0100",
               rsp_valid, rsp_err, rsp_op, rsp_result);
    end
    checks++;
    if (alu_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_start_drop: got start=%b want 0", alu_start);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_drain: got valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    rsp_ready = 1'b1;
    offer(8'hFF, 8'hFF, 3'b100);
    for (int i = 0; i < 5; i++) tick();
    // One op in flight plus four queued: the queue is full now.
    offer(8'h02, 8'h02, 3'b001);
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_full_ready: got ready=%b want 0", cmd_ready);
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_full_refuse: got ready=%b want 0", cmd_ready);
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (alu_start !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      checks++;
      if (alu_start !== 1'b1 || (i > 0 && n < 1)) begin
        errors++;
        $display("[TB] FAIL b2b_start_%0d: got start=%b low_cycles=%0d want start=1 low_cycles>=1", i, alu_start, n);
      end
      checks++;
      if ({alu_op, alu_a, alu_b} !== {3'b100, 8'hFF, 8'hFF}) begin
        errors++;
        $display("[TB] FAIL b2b_operands_%0d: got op=%b a=%h b=%h want 100 ff ff", i, alu_op, alu_a, alu_b);
      end
      tick();
      alu_done = 1'b1; alu_result = 16'hFE01;
      tick();
      alu_done = 1'b0;
      checks++;
      if ({rsp_valid, rsp_err, rsp_op, rsp_result} !== {1'b1, 1'b0, 3'b100, 16'hFE01}) begin
        errors++;
        $display("[TB] FAIL b2b_response_%0d: got valid=%b err=%b op=%b result=%h want 1 0 100 fe01",
                 i, rsp_valid, rsp_err, rsp_op, rsp_result);
      end
      checks++;
      if (alu_start !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_gap_%0d: got start=%b want 0", i, alu_start);
      end
    end
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_drained: got valid=%b busy=%b start=%b want 0 0 0", rsp_valid, busy, alu_start);
    end
  endtask

  task automatic test_backpressure();
    offer(8'h01, 8'h02, 3'b001);
    tick();
    offer(8'h03, 8'h04, 3'b001);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (alu_start !== 1'b1 || alu_a !== 8'h01) begin
      errors++;
      $display("[TB] FAIL bp_first_start: got start=%b a=%h want 1 01", alu_start, alu_a);
    end
    tick();
    alu_done = 1'b1; alu_result = 16'h0003;
    tick();
    alu_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({alu_start, rsp_valid, rsp_result} !== {1'b0, 1'b1, 16'h0003}) begin
        errors++;
        $display("[TB] FAIL bp_hold_%0d: got start=%b valid=%b result=%h want 0 1 0003",
                 i, alu_start, rsp_valid, rsp_result);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, alu_start, alu_a, alu_b} !== {1'b0, 1'b1, 8'h03, 8'h04}) begin
      errors++;
      $display("[TB] FAIL bp_second_start: got valid=%b start=%b a=%h b=%h want 0 1 03 04",
               rsp_valid, alu_start, alu_a, alu_b);
    end
    tick();
    alu_done = 1'b1; alu_result = 16'h0007;
    tick();
    alu_done = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_result} !== {1'b1, 1'b0, 16'h0007}) begin
      errors++;
      $display("[TB] FAIL bp_second_rsp: got valid=%b err=%b result=%h want 1 0 0007", rsp_valid, rsp_err, rsp_result);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_illegal_noop();
    alu_done = 1'b1; alu_result = 16'h1234;
    tick();
    alu_done = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || alu_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stray_done: got valid=%b start=%b want 0 0", rsp_valid, alu_start);
    end
    offer(8'h05, 8'h06, 3'b101);
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++;
    if ({rsp_valid, rsp_err, rsp_op, rsp_result} !== {1'b1, 1'b1, 3'b101, 16'h0000}) begin
      errors++;
      $display("[TB] FAIL illegal_rsp: got valid=%b err=%b op=%b result=%h want 1 1 101 0000",
               rsp_valid, rsp_err, rsp_op, rsp_result);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (alu_start !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL illegal_no_start_%0d: got start=%b busy=%b want 0 0", i, alu_start, busy);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    offer(8'h00, 8'h00, 3'b000);
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++;
    if (alu_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL noop_start: got start=%b want 1", alu_start);
    end
    tick();
    checks++;
    if (alu_start !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL noop_single: got start=%b valid=%b want 0 0", alu_start, rsp_valid);
    end
    tick();
    checks++;
    if (alu_start !== 1'b0 || rsp_valid !== 1'b0 || alu_reset_n !== 1'b1) begin
      errors++;
      $display("[TB] FAIL noop_quiet: got start=%b valid=%b rstn=%b want 0 0 1", alu_start, rsp_valid, alu_reset_n);
    end
  endtask

  task automatic test_timeout();
    int n;
    int guard;
    offer(8'h07, 8'h09, 3'b100);
    tick();
    cmd_valid = 1'b0;
    tick();
    n = 0;
    guard = 0;
    while (alu_start === 1'b1 && guard < 200) begin
      n++;
      tick();
      guard++;
    end
    checks++;
    if (n !== 64) begin
      errors++;
      $display("[TB] FAIL timeout_start_cycles: got %0d want 64", n);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_op, rsp_result} !== {1'b1, 1'b1, 3'b100, 16'h0000}) begin
      errors++;
      $display("[TB] FAIL timeout_rsp: got valid=%b err=%b op=%b result=%h want 1 1 100 0000",
               rsp_valid, rsp_err, rsp_op, rsp_result);
    end
    checks++;
    if (alu_reset_n !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_alu_reset: got rstn=%b want 0", alu_reset_n);
    end
    tick();
    checks++;
    if (alu_reset_n !== 1'b1 || alu_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_recover: got rstn=%b start=%b want 1 0", alu_reset_n, alu_start);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_rst_op();
    offer(8'h00, 8'h00, 3'b111);
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++;
    if (alu_reset_n !== 1'b0 || alu_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstop_pulse: got rstn=%b start=%b want 0 0", alu_reset_n, alu_start);
    end
    tick();
    checks++;
    if (alu_reset_n !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstop_end: got rstn=%b valid=%b busy=%b want 1 0 0", alu_reset_n, rsp_valid, busy);
    end
  endtask

  task automatic test_mid_reset();
    offer(8'h02, 8'h03, 3'b100);
    tick();
    offer(8'h04, 8'h05, 3'b001);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (alu_start !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_running: got start=%b busy=%b want 1 1", alu_start, busy);
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({alu_start, rsp_valid, busy, cmd_ready, alu_reset_n} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL midrst_abort: got start/valid/busy/ready/rstn=%b want 00000",
               {alu_start, rsp_valid, busy, cmd_ready, alu_reset_n});
    end
    reset = 1'b0;
    tick(); tick();
    checks++;
    if (alu_start !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_flushed: got start=%b busy=%b valid=%b want 0 0 0", alu_start, busy, rsp_valid);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_illegal_noop();
    test_timeout();
    test_rst_op();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
